// File: rtl/eof_stream_merge.sv
// eof_stream_merge
//
// Merges NCH input streams into one registered output stream. Channels are
// served round-robin, one beat per cycle in total. Each channel ends its
// stream with an EOF marker. The merger consumes the marker, reports it as a
// one-cycle eof_pulse and records it in a sticky eof_seen flag. Once every
// channel has ended and the output register has drained, done goes high.
//
// Handshake rule for every stream port: a beat transfers on a rising clk edge
// where valid and ready are both high. Valid never depends on ready. The
// producer holds data stable while valid is high and ready is low.
//
// Ports
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   start           : one-cycle pulse, begins a session from IDLE or DONE
//   in_valid/in_eof : per-channel beat valid / beat-is-EOF-marker
//   in_data         : channel c at bits [c*W +: W]
//   in_ready        : per-channel accept, at most one bit high
//   out_valid/out_data/out_ch/out_ready : registered output stream
//   eof_pulse       : one-cycle pulse per accepted EOF marker
//   eof_seen        : sticky per-channel EOF flags
//   beat_count      : saturating count of data beats forwarded this session
//   done            : high in DONE
//   state_dbg       : FSM state (0 IDLE, 1 RUN, 2 FLUSH, 3 DONE)
module eof_stream_merge #(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int CNTW = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [NCH-1:0]                           in_valid,
  input  logic [NCH*W-1:0]                         in_data,
  input  logic [NCH-1:0]                           in_eof,
  output logic [NCH-1:0]                           in_ready,
  output logic                                     out_valid,
  output logic [W-1:0]                             out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  input  logic                                     out_ready,
  output logic [NCH-1:0]                           eof_pulse,
  output logic [NCH-1:0]                           eof_seen,
  output logic [CNTW-1:0]                          beat_count,
  output logic                                     done,
  output logic [1:0]                               state_dbg
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  last_grant_q, last_grant_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CHW-1:0]  out_ch_q, out_ch_d;
  logic [NCH-1:0]  eof_pulse_q, eof_pulse_d;
  logic [NCH-1:0]  eof_seen_q, eof_seen_d;
  logic [CNTW-1:0] beat_count_q, beat_count_d;

  logic [W-1:0]    ch_data [NCH];
  logic [NCH-1:0]  eligible;
  logic            grant_found;
  logic [CHW-1:0]  grant_idx;
  logic [CHW-1:0]  cand;
  logic            grant_eof;
  logic            out_free;
  logic            accept;
  logic            acc_data;
  logic            acc_eof;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign ch_data[c] = in_data[c*W +: W];
  end

  // Channels that have already ended are masked out, so a stale in_valid on
  // them can never win the arbitration.
  assign eligible = in_valid & ~eof_seen_q;

  // Round-robin search starting one past the last accepted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CHW'((int'(last_grant_q) + k) % NCH);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_eof = in_eof[grant_idx];
  assign out_free  = !out_valid_q || out_ready;

  // EOF markers never occupy the output register, so they are accepted even
  // while the output is stalled.
  assign accept   = (state_q == S_RUN) && grant_found && (grant_eof || out_free);
  assign acc_data = accept && !grant_eof;
  assign acc_eof  = accept && grant_eof;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    eof_pulse_d  = '0;
    eof_seen_d   = eof_seen_q;
    beat_count_d = beat_count_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) last_grant_d = grant_idx;

    if (acc_data) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      if (beat_count_q != '1) beat_count_d = beat_count_q + CNTW'(1);
    end

    if (acc_eof) begin
      eof_seen_d[grant_idx]  = 1'b1;
      eof_pulse_d[grant_idx] = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // in_ready is low here, so the clears never collide with an accept.
        if (start) begin
          state_d      = S_RUN;
          eof_seen_d   = '0;
          beat_count_d = '0;
        end
      end
      S_RUN: begin
        if (&eof_seen_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!out_valid_q || out_ready) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= CHW'(NCH - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      eof_pulse_q  <= '0;
      eof_seen_q   <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      eof_pulse_q  <= eof_pulse_d;
      eof_seen_q   <= eof_seen_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign eof_pulse  = eof_pulse_q;
  assign eof_seen   = eof_seen_q;
  assign beat_count = beat_count_q;
  assign done       = (state_q == S_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_eof_stream_merge.sv
// Testbench for eof_stream_merge (NCH=4, W=8). A second instance with CNTW=4
// shares the same inputs to observe beat_count saturation.
module tb_eof_stream_merge;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_eof;
  logic        out_ready;

  logic [3:0]  in_ready,   s_in_ready;
  logic        out_valid,  s_out_valid;
  logic [7:0]  out_data,   s_out_data;
  logic [1:0]  out_ch,     s_out_ch;
  logic [3:0]  eof_pulse,  s_eof_pulse;
  logic [3:0]  eof_seen,   s_eof_seen;
  logic [15:0] beat_count;
  logic [3:0]  s_beat_count;
  logic        done,       s_done;
  logic [1:0]  state_dbg,  s_state_dbg;

  always #5 clk = ~clk;

  eof_stream_merge #(.NCH(4), .W(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready), .eof_pulse(eof_pulse),
    .eof_seen(eof_seen), .beat_count(beat_count), .done(done),
    .state_dbg(state_dbg)
  );

  eof_stream_merge #(.NCH(4), .W(8), .CNTW(4)) dut_s (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ch(s_out_ch), .out_ready(out_ready), .eof_pulse(s_eof_pulse),
    .eof_seen(s_eof_seen), .beat_count(s_beat_count), .done(s_done),
    .state_dbg(s_state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [9:0] exp_q[$];    // {channel, data} of beats expected on the output
  int         n_cmp = 0;
  int         n_err = 0;

  int         m_state;     // 0 IDLE, 1 RUN, 2 FLUSH, 3 DONE
  int         m_last;
  logic [3:0] m_eof;
  logic [3:0] m_pulse;
  logic       m_ov;
  int         m_cnt;
  int         m_cnt_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 3;
    m_eof   = 4'b0;
    m_pulse = 4'b0;
    m_ov    = 1'b0;
    m_cnt   = 0;
    m_cnt_s = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs are already driven (at the falling edge). Checks combinational
  // outputs before the rising edge and registered outputs after it.
  task automatic cycle();
    int          gi;
    int          nstate;
    logic        acc;
    logic [3:0]  exp_rdy;
    logic [31:0] sh;
    #1;
    gi      = -1;
    exp_rdy = 4'b0;
    if (m_state == 1) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (gi < 0 && in_valid[c] && !m_eof[c]) gi = c;
      end
    end
    acc = (gi >= 0) && (in_eof[gi] || !m_ov || out_ready);
    if (acc) exp_rdy[gi] = 1'b1;

    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("in_ready_s", 32'(s_in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov && exp_q.size() > 0) chk("out_beat", 32'({out_ch, out_data}), 32'(exp_q[0]));

    nstate = m_state;
    case (m_state)
      0, 3: if (start) nstate = 1;
      1: if (&m_eof) nstate = 2;
      2: if (!m_ov || out_ready) nstate = 3;
      default: nstate = 0;
    endcase

    if (m_ov && out_ready) begin
      void'(exp_q.pop_front());
      m_ov = 1'b0;
    end
    m_pulse = 4'b0;
    if (acc) begin
      m_last = gi;
      if (in_eof[gi]) begin
        m_eof[gi]   = 1'b1;
        m_pulse[gi] = 1'b1;
      end else begin
        sh = in_data >> (gi * 8);
        exp_q.push_back({2'(gi), sh[7:0]});
        m_ov = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
    if ((m_state == 0 || m_state == 3) && start) begin
      m_eof   = 4'b0;
      m_cnt   = 0;
      m_cnt_s = 0;
    end
    m_state = nstate;

    @(posedge clk);
    #1;
    chk("eof_pulse", 32'(eof_pulse), 32'(m_pulse));
    chk("eof_seen", 32'(eof_seen), 32'(m_eof));
    chk("beat_count", 32'(beat_count), 32'(m_cnt));
    chk("beat_count_sat", 32'(s_beat_count), 32'(m_cnt_s));
    chk("done", 32'(done), 32'(m_state == 3));
    chk("state", 32'(state_dbg), 32'(m_state));
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    chk({tag, "_eof_pulse"}, 32'(eof_pulse), 32'd0);
    chk({tag, "_eof_seen"}, 32'(eof_seen), 32'd0);
    chk({tag, "_beat_count"}, 32'(beat_count), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 4'hF;
    in_eof    = 4'h0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // All channels stream fixed data, output always ready.
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    repeat (22) cycle();
    chk("count_after_22", 32'(beat_count), 32'd22);
    chk("count_sat_15", 32'(s_beat_count), 32'd15);

    // Channel 2 ends while the others keep streaming.
    in_eof = 4'b0100;
    repeat (4) cycle();
    in_eof = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom();
      cycle();
    end
    chk("eof_seen_ch2", 32'(eof_seen), 32'h4);

    // Output stalled; channel 1 offers an EOF marker.
    out_ready = 1'b0;
    in_eof    = 4'b0010;
    repeat (3) cycle();
    in_valid = 4'b0110;
    repeat (2) cycle();
    chk("eof_seen_ch1", 32'(eof_seen), 32'h6);

    // Remaining channels end while a beat is still stuck in the output.
    in_valid = 4'b1001;
    in_eof   = 4'b1001;
    repeat (6) cycle();
    chk("flush_state", 32'(state_dbg), 32'd2);
    chk("flush_done_low", 32'(done), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("done_after_drain", 32'(done), 32'd1);
    cycle();

    // New session from DONE with beats already on offer.
    in_valid = 4'hF;
    in_eof   = 4'h0;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_data   = $urandom();
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Reset while a beat sits in the output register.
    out_ready = 1'b0;
    cycle();
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h44332211;
    out_ready = 1'b1;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("restart_ch0_first", 32'(out_ch), 32'd0);
    chk("restart_data", 32'(out_data), 32'h11);
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
